mux_sel_serializer: RTL and testbench
=====================================

// Module: mux_sel_serializer
// PURPOSE
//  Sequencer that sits directly upstream of the 8:1 mux datapath. It accepts an 8-bit word
//  over a valid/ready handshake and steps the s2/s1/s0 select lines through all 8 positions.
//  It presents the selected bit (word[sel]) as a serial stream qualified by ser_valid.
//  Used as the parallel-to-serial front end wherever an 8:1 mux is scanned in sequence.
// PARAMETERS
//  BIT_CYCLES  1  clock cycles each bit/select is held; legal 1..16
//  MSB_FIRST   0  0: sel counts 0->7 (d0 first); 1: sel counts 7->0 (d7 first)
//  GAP_CYCLES  0  idle cycles forced after each frame before next accept; legal 0..15
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  upstream word valid
//  in_data    in   8  word to serialize; bit i drives mux input d<i>
//  in_ready   out  1  block can accept a word this cycle
//  s2,s1,s0   out  1  select lines to the 8:1 mux (s2 = MSB)
//  ser_out    out  1  selected bit, word[{s2,s1,s0}]
//  ser_valid  out  1  ser_out carries a frame bit this cycle
//  frame_start out 1  1-cycle pulse on the first cycle of bit 0 of a frame
//  done       out  1  1-cycle pulse on the last cycle of the last bit
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; word=0; sel=START (0, or 7 if MSB_FIRST);
//   hold/gap counters=0; ser_out=0, ser_valid=0, frame_start=0, done=0, busy=0, in_ready=0
//   during reset, 1 from the first clock edge after release.
//  States: IDLE, SHIFT, GAP.
//  IDLE: in_ready=1, ser_valid=0, ser_out=0, sel held at START. On in_valid&&in_ready at an
//   edge, word<=in_data, hold<=BIT_CYCLES-1, and the state becomes SHIFT. The first bit
//   is valid in the next cycle (latency 1).
//  SHIFT: ser_valid=1; ser_out=word[sel] (combinational from registered word/sel).
//   frame_start=1 in the first cycle of the frame.
//   hold decrements each cycle. When hold==0: if the current bit is not the last, sel steps
//   +1 (or -1 if MSB_FIRST) and hold reloads to BIT_CYCLES-1.
//   Frame length is exactly 8*BIT_CYCLES cycles.
//  Last cycle (last sel, hold==0): done=1.
//   If GAP_CYCLES==0, in_ready=1 in this cycle. An accept here loads the new word and stays
//   in SHIFT with sel=START and frame_start=1 next cycle, so back-to-back frames have no
//   bubble. With no accept, the state becomes IDLE.
//   If GAP_CYCLES>0, in_ready=0 and the state becomes GAP.
//  GAP: ser_valid=0, in_ready=0, sel=START. Lasts exactly GAP_CYCLES cycles, then IDLE.
//  in_valid while in_ready=0 is ignored; in_data is sampled only on an accept.
//   The word register is unaffected by in_data changes mid-frame.
//  sel wraps never: it stops at the last index and is reloaded to START on frame end.
//  rst asserted mid-frame: all outputs take reset values immediately. The in-flight word
//   is discarded and no done pulse is issued.
//  {s2,s1,s0} is always a registered output (glitch-free at the mux).
// TESTING
//  T1 BIT_CYCLES=1, MSB_FIRST=0, accept 8'h0A -> sel 0..7 over 8 cycles.
//     ser_out = 0,1,0,1,0,0,0,0; frame_start on cycle 1; done on cycle 8; then IDLE.
//  T2 MSB_FIRST=1, accept 8'hA5 -> sel 7..0; ser_out = 1,0,1,0,0,1,0,1.
//  T3 BIT_CYCLES=3, accept 8'h81 -> 24 ser_valid cycles, each bit held 3 cycles.
//     ser_out high in cycles 1-3 and 22-24 only.
//  T4 GAP_CYCLES=0, in_valid held with 8'hFF then 8'h00 -> 16 contiguous ser_valid cycles.
//     Eight 1s then eight 0s; two done pulses, two frame_start pulses, no bubble.
//  T5 GAP_CYCLES=2 -> after done, in_ready=0 for 2 cycles, then the next word is accepted.
//     Toggling in_valid/in_data mid-frame has no effect on ser_out.
//  T6 Accept 8'hFF, assert rst at sel=4 -> outputs reset asynchronously with no done pulse.
//     After release, accepting 8'h01 starts at sel=0 with ser_out=1, then 0.

Source files
------------

// File: rtl/mux_sel_serializer.sv
// Parallel-to-serial sequencer for an 8:1 mux: accepts a byte over valid/ready and walks
// the registered select lines {s2,s1,s0} through all eight positions, presenting word[sel].
module mux_sel_serializer #(
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       frame_start,
  output logic       done,
  output logic       busy
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready are both high;
  // in_ready does not depend on in_valid, and in_data is sampled only on that edge.

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [2:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_LAST  = (MSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [3:0] HOLD_INIT = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] GAP_INIT  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic       NO_GAP    = (GAP_CYCLES == 0);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] word;
  logic [2:0] sel;
  logic [3:0] hold;
  logic [3:0] gap_cnt;
  logic       live;
  logic       first;
  logic       accept;
  logic       last_cycle;

  assign last_cycle = (state == SHIFT) && (sel == SEL_LAST) && (hold == 4'd0);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_cycle) begin
          if (accept)          state_nxt = SHIFT;
          else if (!NO_GAP)    state_nxt = GAP;
          else                 state_nxt = IDLE;
        end
      end
      GAP:     if (gap_cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // live holds in_ready low until the first edge after reset release.
  always_comb begin
    in_ready    = live && ((state == IDLE) || (NO_GAP && last_cycle));
    ser_valid   = (state == SHIFT);
    ser_out     = (state == SHIFT) && word[sel];
    frame_start = first;
    done        = last_cycle;
    busy        = (state != IDLE);
    {s2, s1, s0} = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= 8'd0;
      sel     <= SEL_START;
      hold    <= 4'd0;
      gap_cnt <= 4'd0;
      live    <= 1'b0;
      first   <= 1'b0;
    end else begin
      live  <= 1'b1;
      first <= accept;
      if (accept) begin
        word <= in_data;
        sel  <= SEL_START;
        hold <= HOLD_INIT;
      end else begin
        case (state)
          SHIFT: begin
            if (hold != 4'd0) begin
              hold <= hold - 4'd1;
            end else if (sel != SEL_LAST) begin
              sel  <= (MSB_FIRST != 0) ? sel - 3'd1 : sel + 3'd1;
              hold <= HOLD_INIT;
            end else begin
              // Frame end without a follow-on word: park sel and arm the gap timer.
              sel     <= SEL_START;
              gap_cnt <= GAP_INIT;
            end
          end
          GAP: begin
            sel <= SEL_START;
            if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          end
          default: sel <= SEL_START;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Bench for mux_sel_serializer: three configurations side by side, each checked cycle by
// cycle against a bit-stream model built from the word, bit order and hold length.
module tb_mux_sel_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv [3];
  logic [7:0] id [3];
  logic       ir [3];
  logic       s2 [3];
  logic       s1 [3];
  logic       s0 [3];
  logic       so [3];
  logic       sv [3];
  logic       fs [3];
  logic       dn [3];
  logic       bz [3];

  int n_chk  = 0;
  int n_pass = 0;

  mux_sel_serializer #(.BIT_CYCLES(1), .MSB_FIRST(0), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
    .s2(s2[0]), .s1(s1[0]), .s0(s0[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .done(dn[0]), .busy(bz[0]));

  mux_sel_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
    .s2(s2[1]), .s1(s1[1]), .s0(s0[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .done(dn[1]), .busy(bz[1]));

  mux_sel_serializer #(.BIT_CYCLES(3), .MSB_FIRST(0), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
    .s2(s2[2]), .s1(s1[2]), .s0(s0[2]), .ser_out(so[2]), .ser_valid(sv[2]),
    .frame_start(fs[2]), .done(dn[2]), .busy(bz[2]));

  function automatic int bc_of(int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic int msb_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int gap_of(int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic logic [2:0] start_of(int k);
    return (msb_of(k) != 0) ? 3'd7 : 3'd0;
  endfunction

  // Expected per-cycle record: {ser_valid, ser_out, frame_start, done, sel}
  logic [6:0] exp_q[$];

  function automatic logic [6:0] observe(int k);
    return {sv[k], so[k], fs[k], dn[k], s2[k], s1[k], s0[k]};
  endfunction

  task automatic model_frame(input int k, input logic [7:0] w);
    int n;
    n = 8 * bc_of(k);
    for (int c = 0; c < n; c++) begin
      int pos;
      logic [2:0] idx;
      pos = c / bc_of(k);
      idx = 3'((msb_of(k) != 0) ? 7 - pos : pos);
      exp_q.push_back({1'b1, w[idx], (c == 0), (c == n - 1), idx});
    end
  endtask

  // Driver: call at a negedge; returns just after the accepting rising edge.
  task automatic drive_accept(input int k, input logic [7:0] w);
    bit ok;
    ok = 0;
    iv[k] = 1'b1;
    id[k] = w;
    for (int t = 0; t < 64; t++) begin
      if (ir[k] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
    end else begin
      n_chk++;
      $display("FAIL accept_timeout inst %0d: in_ready never rose, required 1", k);
      iv[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      id[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({observe(k), ir[k], bz[k]} !== {4'b0000, start_of(k), 2'b00})
        $display("FAIL reset_state inst %0d: got %b required %b", k,
                 {observe(k), ir[k], bz[k]}, {4'b0000, start_of(k), 2'b00});
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({ir[k], bz[k], sv[k], s2[k], s1[k], s0[k]} !== {3'b100, start_of(k)})
        $display("FAIL reset_release inst %0d: got ir/bz/sv/sel %b required %b", k,
                 {ir[k], bz[k], sv[k], s2[k], s1[k], s0[k]}, {3'b100, start_of(k)});
      else n_pass++;
    end
  endtask

  task automatic test_frame(input int k, input logic [7:0] w, input string name);
    int n;
    logic [6:0] e;
    n = 8 * bc_of(k);
    exp_q.delete();
    model_frame(k, w);
    drive_accept(k, w);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (observe(k) !== e)
        $display("FAIL %s cycle %0d: got v/o/fs/dn/sel %b required %b", name, c, observe(k), e);
      else n_pass++;
      // Upstream noise mid-frame must not disturb the word in flight.
      id[k] = 8'($urandom);
      if (gap_of(k) > 0 && c < n - 1) iv[k] = 1'($urandom_range(0, 1));
      else                            iv[k] = 1'b0;
    end
    for (int g = 0; g < gap_of(k); g++) begin
      @(negedge clk);
      n_chk++;
      if ({ir[k], bz[k], sv[k]} !== 3'b010)
        $display("FAIL %s gap %0d: got ir/bz/sv %b required 010", name, g, {ir[k], bz[k], sv[k]});
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if ({ir[k], bz[k], sv[k], dn[k], s2[k], s1[k], s0[k]} !== {4'b1000, start_of(k)})
      $display("FAIL %s idle_after: got ir/bz/sv/dn/sel %b required %b", name,
               {ir[k], bz[k], sv[k], dn[k], s2[k], s1[k], s0[k]}, {4'b1000, start_of(k)});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [6:0] e;
    exp_q.delete();
    model_frame(0, 8'hFF);
    model_frame(0, 8'h00);
    drive_accept(0, 8'hFF);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (observe(0) !== e)
        $display("FAIL back_to_back cycle %0d: got v/o/fs/dn/sel %b required %b", c, observe(0), e);
      else n_pass++;
      if (c == 0) id[0] = 8'h00;
      if (c == 8) iv[0] = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if ({ir[0], bz[0], sv[0]} !== 3'b100)
      $display("FAIL back_to_back idle_after: got ir/bz/sv %b required 100", {ir[0], bz[0], sv[0]});
    else n_pass++;
  endtask

  task automatic test_random_frames;
    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(0, 2);
      test_frame(k, 8'($urandom), "random_frame");
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] e;
    exp_q.delete();
    model_frame(0, 8'hFF);
    drive_accept(0, 8'hFF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (observe(0) !== e)
        $display("FAIL pre_reset cycle %0d: got v/o/fs/dn/sel %b required %b", c, observe(0), e);
      else n_pass++;
      iv[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({observe(0), ir[0], bz[0]} !== 9'b0)
      $display("FAIL async_reset: got %b required 000000000", {observe(0), ir[0], bz[0]});
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({dn[0], sv[0], bz[0]} !== 3'b000)
        $display("FAIL reset_hold %0d: got dn/sv/bz %b required 000", c, {dn[0], sv[0], bz[0]});
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    test_frame(0, 8'h01, "restart_after_reset");
  endtask

  initial begin
    test_reset();
    test_frame(0, 8'h0A, "lsb_first_0a");
    test_frame(1, 8'hA5, "msb_first_a5");
    test_frame(2, 8'h81, "hold3_gap2_81");
    test_frame(2, 8'h3C, "after_gap_3c");
    test_back_to_back();
    test_random_frames();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
